// File: rtl/memoria_pkg.sv
// Shared definitions for the memoria memory and its two-port arbiter.
// Holds default geometry and the arbiter FSM state encoding.
package memoria_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Port index that did not win; the round-robin pointer hands the next tie to it.
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/memarb_pick2.sv
// Combinational winner select between two requesters.
// MEMARB_FIXED_PRIO_EN: port 0 always wins ties; otherwise ties go to the port not granted last.
module memarb_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic win
);

`ifdef MEMARB_FIXED_PRIO_EN
  logic unused_last_s;
  assign unused_last_s = last;
`endif

  // Select the winning port index (0 or 1) and flag that a request exists.
  always_comb begin
    any = req0 | req1;
    win = 1'b0;
    if (req0 && req1) begin
`ifdef MEMARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last;
`endif
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

endmodule

// File: rtl/memoria.sv
// 32x14 single-port synchronous memory: write on en&wr, registered read on en&~wr.
// The array has no reset; dataout updates only on a read edge.
module memoria #(
  parameter int ADDR_W = memoria_pkg::ADDR_W,
  parameter int DATA_W = memoria_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout
);

  logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

  // Single access port: one write or one read per enabled edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) begin
        mem_r[address] <= datain;
      end else begin
        dataout <= mem_r[address];
      end
    end
  end

endmodule

// File: rtl/memoria_arbiter.sv
// Two-port arbiter/sequencer for the memoria memory: IDLE -> ISSUE -> RESP, one op per 3 cycles.
// Tie-break is round-robin unless MEMARB_FIXED_PRIO_EN is defined (port 0 fixed priority).
module memoria_arbiter #(
  parameter int ADDR_W = memoria_pkg::ADDR_W,
  parameter int DATA_W = memoria_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  import memoria_pkg::*;

  state_t state_r;
  logic   last_r;
  logic   port_r;
  logic   op_wr_r;
  logic   any_s;
  logic   win_s;

  memarb_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last_r),
    .any  (any_s),
    .win  (win_s)
  );

  // Sequencer FSM; every output is a register written only here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      last_r      <= 1'b1;
      port_r      <= 1'b0;
      op_wr_r     <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata       <= {DATA_W{1'b0}};
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_address <= {ADDR_W{1'b0}};
      mem_datain  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (any_s) begin
            gnt0        <= ~win_s;
            gnt1        <= win_s;
            mem_en      <= 1'b1;
            mem_wr      <= win_s ? wr1 : wr0;
            op_wr_r     <= win_s ? wr1 : wr0;
            mem_address <= win_s ? addr1 : addr0;
            mem_datain  <= win_s ? wdata1 : wdata0;
            port_r      <= win_s;
            last_r      <= win_s;
            state_r     <= ST_ISSUE;
          end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        // The memory samples en=1 at this edge; address/datain stay put afterwards.
        ST_ISSUE: begin
          mem_en  <= 1'b0;
          mem_wr  <= 1'b0;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          done0 <= ~port_r;
          done1 <= port_r;
          if (!op_wr_r) begin
            rdata <= mem_dataout;
          end else begin
            rdata <= rdata;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          done0   <= 1'b0;
          done1   <= 1'b0;
          mem_en  <= 1'b0;
          mem_wr  <= 1'b0;
          last_r  <= other_port(1'b0);
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_arbiter.sv
// Randomized bench for memoria_arbiter + memoria against a transaction-level reference model.
// Honours MEMARB_FIXED_PRIO_EN for the expected tie-break.
module tb_memoria_arbiter;

  localparam int AW = 5;
  localparam int DW = 14;

  logic          clk;
  logic          rst;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain, mem_dataout;

  memoria_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_address(mem_address),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  memoria #(.ADDR_W(AW), .DATA_W(DW)) u_mem (
    .clk(clk), .en(mem_en), .wr(mem_wr), .address(mem_address),
    .datain(mem_datain), .dataout(mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [0:31];
  logic [DW-1:0] exp_rdata;
  logic          last_m;
  logic          pend  [0:1];
  logic          pwr   [0:1];
  logic [AW-1:0] paddr [0:1];
  logic [DW-1:0] pdata [0:1];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    req0 = pend[0]; wr0 = pwr[0]; addr0 = paddr[0]; wdata0 = pdata[0];
    req1 = pend[1]; wr1 = pwr[1]; addr1 = paddr[1]; wdata1 = pdata[1];
  endtask

  task automatic set_req(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; pwr[p] = w; paddr[p] = a; pdata[p] = d;
  endtask

  task automatic model_reset();
    last_m = 1'b1;
    exp_rdata = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
  endtask

  // One arbitration round starting at a negedge with the DUT idle.
  task automatic run_txn();
    logic w;
    logic [DW-1:0] nxt;
    drive_reqs();
    if (!pend[0] && !pend[1]) begin
      @(negedge clk);
      check_eq("idle_gnt", 32'({gnt1, gnt0}), 32'd0);
      check_eq("idle_en", 32'(mem_en), 32'd0);
      check_eq("idle_done", 32'({done1, done0}), 32'd0);
      check_eq("idle_rdata", 32'(rdata), 32'(exp_rdata));
    end else begin
      if (pend[0] && pend[1]) begin
`ifdef MEMARB_FIXED_PRIO_EN
        w = 1'b0;
`else
        w = (last_m == 1'b1) ? 1'b0 : 1'b1;
`endif
      end else begin
        w = pend[1];
      end
      last_m = w;
      nxt = exp_rdata;
      @(negedge clk);
      check_eq("gnt", 32'({gnt1, gnt0}), (w == 1'b0) ? 32'd1 : 32'd2);
      check_eq("gnt_done", 32'({done1, done0}), 32'd0);
      check_eq("en_on", 32'(mem_en), 32'd1);
      check_eq("mem_wr", 32'(mem_wr), 32'(pwr[w]));
      check_eq("mem_addr", 32'(mem_address), 32'(paddr[w]));
      check_eq("mem_datain", 32'(mem_datain), 32'(pdata[w]));
      if (pwr[w]) ref_mem[paddr[w]] = pdata[w];
      else nxt = ref_mem[paddr[w]];
      pend[w] = 1'b0;
      drive_reqs();
      @(negedge clk);
      check_eq("en_off", 32'({mem_en, mem_wr}), 32'd0);
      check_eq("gnt_off", 32'({gnt1, gnt0}), 32'd0);
      check_eq("resp_done", 32'({done1, done0}), 32'd0);
      @(negedge clk);
      exp_rdata = nxt;
      check_eq("done", 32'({done1, done0}), (w == 1'b0) ? 32'd1 : 32'd2);
      check_eq("rdata", 32'(rdata), 32'(exp_rdata));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      pwr[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
    end
    model_reset();
    drive_reqs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check_eq("rst_done", 32'({done1, done0}), 32'd0);
    check_eq("rst_mem", 32'({mem_en, mem_wr}), 32'd0);
    check_eq("rst_addr", 32'(mem_address), 32'd0);
    check_eq("rst_datain", 32'(mem_datain), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    repeat (3) run_txn();

    // Port 0 write 3FFF to 4 then read it back
    set_req(1'b0, 1'b1, 5'd4, 14'h3FFF); run_txn();
    set_req(1'b0, 1'b0, 5'd4, 14'h0000); run_txn();

    // Fill memory so every later read has a known value
    for (int a = 0; a < 32; a++) begin
      if (a != 4) begin
        set_req(1'b0, 1'b1, 5'(a), 14'($urandom_range(16383)));
        run_txn();
      end
    end

    // Continuous contention, reads of 2 and 3
    for (int k = 0; k < 8; k++) begin
      set_req(1'b0, 1'b0, 5'd2, 14'h0000);
      set_req(1'b1, 1'b0, 5'd3, 14'h0000);
      run_txn();
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    run_txn();

    // Wrap address 31; a later write leaves rdata untouched
    set_req(1'b1, 1'b1, 5'h1F, 14'h2AAA); run_txn();
    set_req(1'b0, 1'b0, 5'h1F, 14'h0000); run_txn();
    check_eq("wrap_rdata", 32'(rdata), 32'h2AAA);
    set_req(1'b1, 1'b1, 5'd9, 14'h1234); run_txn();
    check_eq("wr_keeps_rdata", 32'(rdata), 32'h2AAA);

    // Reset during ISSUE: the write still lands, no done1
    set_req(1'b1, 1'b1, 5'd7, 14'h0155);
    drive_reqs();
    @(negedge clk);
    check_eq("rsti_gnt", 32'(gnt1), 32'd1);
    rst = 1'b1; pend[1] = 1'b0; drive_reqs();
    @(negedge clk);
    check_eq("rsti_en", 32'(mem_en), 32'd0);
    check_eq("rsti_gnt_clr", 32'({gnt1, gnt0}), 32'd0);
    rst = 1'b0;
    ref_mem[7] = 14'h0155;
    model_reset();
    @(negedge clk);
    check_eq("rsti_no_done", 32'({done1, done0}), 32'd0);
    set_req(1'b0, 1'b0, 5'd7, 14'h0000); run_txn();
    check_eq("rsti_readback", 32'(rdata), 32'h0155);

    // Reset during RESP suppresses done
    set_req(1'b0, 1'b0, 5'd4, 14'h0000);
    drive_reqs();
    @(negedge clk);
    pend[0] = 1'b0; drive_reqs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstr_no_done", 32'({done1, done0}), 32'd0);
    check_eq("rstr_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    model_reset();
    run_txn();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(9) < 6)) begin
          set_req(1'(p), 1'($urandom_range(1)), 5'($urandom_range(31)), 14'($urandom_range(16383)));
        end
      end
      run_txn();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
